demux_1x2_23bit_stream: RTL and testbench

- Inverse of the 2x1 23-bit mantissa mux. It takes one stream of 23-bit mantissa words and steers each word to one of two consumer channels, A or B, chosen by a select bit.
- Each channel has a small in-order FIFO, so the two consumers in the FP datapath can stall independently.
- All transfers use a valid/ready handshake. Data crosses from input to output with 1 cycle of registered latency.

---
 rtl/demux_1x2_23bit_stream_pkg.sv | 9 +
 rtl/demux_1x2_23bit_stream_if.sv | 32 +++
 rtl/demux_1x2_23bit_stream_fifo.sv | 65 ++++++
 rtl/demux_1x2_23bit_stream.sv | 64 ++++++
 tb/tb_demux_1x2_23bit_stream.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/demux_1x2_23bit_stream_pkg.sv
// Shared floating-point datapath constants used by the mantissa stream demux.
package demux_1x2_23bit_stream_pkg;

  localparam int MANT_W = 23;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/demux_1x2_23bit_stream_if.sv
// Valid/ready bundle for the 1x2 mantissa demux: one producer side, two consumer channels.
interface demux_1x2_23bit_stream_if
  import demux_1x2_23bit_stream_pkg::*;
#(
  parameter int WIDTH = MANT_W
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;

  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;

  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;

  // master is the environment (producer + both consumers), slave is the demux
  modport master (
    output in_valid, in_data, in_sel, a_ready, b_ready,
    input  in_ready, a_valid, a_data, b_valid, b_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, a_ready, b_ready,
    output in_ready, a_valid, a_data, b_valid, b_data
  );

endinterface

// File: rtl/demux_1x2_23bit_stream_fifo.sv
// Small in-order FIFO for one demux channel; head_data holds the last popped word once drained.
module stream_fifo_23bit
  import demux_1x2_23bit_stream_pkg::*;
#(
  parameter int WIDTH = MANT_W,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] last_q;
  logic             push_en;
  logic             pop_en;

  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_en) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // When drained, keep presenting the word that was just consumed rather than stale storage
  assign head_data = empty ? last_q : mem[rd_ptr];

endmodule

// File: rtl/demux_1x2_23bit_stream.sv
// 1x2 mantissa stream demux: steers each accepted word into channel A or B by in_sel.
module demux_1x2_23bit_stream
  import demux_1x2_23bit_stream_pkg::*;
#(
  parameter int WIDTH = MANT_W,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  demux_1x2_23bit_stream_if.slave   bus,
  output logic [CW-1:0]             a_count,
  output logic [CW-1:0]             b_count
);

  logic a_full;
  logic b_full;
  logic a_empty;
  logic b_empty;
  logic a_push;
  logic b_push;

  // Back-pressure comes only from the destination's full flag, never from consumer ready
  assign bus.in_ready = (bus.in_sel == SEL_B) ? !b_full : !a_full;

  assign a_push = bus.in_valid && bus.in_ready && (bus.in_sel == SEL_A);
  assign b_push = bus.in_valid && bus.in_ready && (bus.in_sel == SEL_B);

  assign bus.a_valid = !a_empty;
  assign bus.b_valid = !b_empty;

  stream_fifo_23bit #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (a_push),
    .push_data (bus.in_data),
    .pop       (bus.a_ready),
    .head_data (bus.a_data),
    .count     (a_count),
    .full      (a_full),
    .empty     (a_empty)
  );

  stream_fifo_23bit #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (b_push),
    .push_data (bus.in_data),
    .pop       (bus.b_ready),
    .head_data (bus.b_data),
    .count     (b_count),
    .full      (b_full),
    .empty     (b_empty)
  );

endmodule

// File: tb/tb_demux_1x2_23bit_stream.sv
// Self-checking bench: queue-based channel model compared every cycle, plus directed literal checks.
module tb_demux_1x2_23bit_stream;

  localparam int WIDTH = 23;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_n;
  logic [CW-1:0] a_count;
  logic [CW-1:0] b_count;

  int vectors;
  int miscompares;
  bit check_en;

  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  logic [WIDTH-1:0] last_a;
  logic [WIDTH-1:0] last_b;

  demux_1x2_23bit_stream_if #(.WIDTH(WIDTH)) bus ();

  demux_1x2_23bit_stream #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .a_count (a_count),
    .b_count (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input bit sel, input logic [WIDTH-1:0] d,
                               input bit ar, input bit br);
    bus.in_valid = v;
    bus.in_sel   = sel;
    bus.in_data  = d;
    bus.a_ready  = ar;
    bus.b_ready  = br;
  endtask

  task automatic clearModel();
    qa.delete();
    qb.delete();
    last_a = '0;
    last_b = '0;
  endtask

  // Model advances one transfer cycle using the inputs and occupancy seen just before the edge
  task automatic modelUpdate();
    bit a_pop, b_pop, accept;
    a_pop  = bus.a_ready && (qa.size() > 0);
    b_pop  = bus.b_ready && (qb.size() > 0);
    accept = bus.in_valid && (bus.in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH));
    if (a_pop) last_a = qa.pop_front();
    if (b_pop) last_b = qb.pop_front();
    if (accept) begin
      if (bus.in_sel) qb.push_back(bus.in_data);
      else            qa.push_back(bus.in_data);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) modelUpdate();
    #1;
  endtask

  always @(negedge clk) begin
    if (check_en && rst_n) begin
      checkOutput("a_valid", 32'(bus.a_valid), 32'(qa.size() > 0));
      checkOutput("a_data",  32'(bus.a_data),  32'((qa.size() > 0) ? qa[0] : last_a));
      checkOutput("a_count", 32'(a_count),     32'(qa.size()));
      checkOutput("b_valid", 32'(bus.b_valid), 32'(qb.size() > 0));
      checkOutput("b_data",  32'(bus.b_data),  32'((qb.size() > 0) ? qb[0] : last_b));
      checkOutput("b_count", 32'(b_count),     32'(qb.size()));
      checkOutput("in_ready", 32'(bus.in_ready),
                  32'(bus.in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH)));
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    check_en    = 1'b0;
    clearModel();
    rst_n = 1'b0;
    applyStimulus(0, 0, '0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("reset a_valid",  32'(bus.a_valid),  32'd0);
    rst_n    = 1'b1;
    check_en = 1'b1;
    step();
    checkOutput("idle a_valid", 32'(bus.a_valid), 32'd0);
    checkOutput("idle b_valid", 32'(bus.b_valid), 32'd0);
    checkOutput("idle a_count", 32'(a_count),     32'd0);
    checkOutput("idle b_count", 32'(b_count),     32'd0);
    checkOutput("idle a_data",  32'(bus.a_data),  32'd0);
    checkOutput("idle b_data",  32'(bus.b_data),  32'd0);
    checkOutput("idle in_ready", 32'(bus.in_ready), 32'd1);

    // Route to A
    applyStimulus(1, 0, 23'd1, 0, 0);
    step();
    applyStimulus(0, 0, '0, 0, 0);
    checkOutput("routeA a_valid", 32'(bus.a_valid), 32'd1);
    checkOutput("routeA a_data",  32'(bus.a_data),  32'd1);
    checkOutput("routeA a_count", 32'(a_count),     32'd1);
    checkOutput("routeA b_valid", 32'(bus.b_valid), 32'd0);

    // Route to B with consumer ready
    applyStimulus(1, 1, 23'd2, 0, 1);
    step();
    checkOutput("routeB b_valid", 32'(bus.b_valid), 32'd1);
    checkOutput("routeB b_data",  32'(bus.b_data),  32'd2);
    applyStimulus(0, 1, '0, 0, 1);
    step();
    checkOutput("routeB drained b_valid", 32'(bus.b_valid), 32'd0);
    checkOutput("routeB drained b_count", 32'(b_count),     32'd0);
    checkOutput("routeB held b_data",     32'(bus.b_data),  32'd2);

    applyStimulus(0, 0, '0, 1, 0);
    step();
    checkOutput("drainA a_count", 32'(a_count), 32'd0);

    // Back-pressure independence
    applyStimulus(1, 0, 23'd10, 0, 0);
    step();
    applyStimulus(1, 0, 23'd11, 0, 0);
    step();
    checkOutput("bp a_count",  32'(a_count),      32'd2);
    checkOutput("bp in_ready", 32'(bus.in_ready), 32'd0);
    applyStimulus(1, 1, 23'd12, 0, 0);
    #1;
    checkOutput("bp in_ready selB", 32'(bus.in_ready), 32'd1);
    step();
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("bp b_data",   32'(bus.b_data), 32'd12);
    checkOutput("bp a_count2", 32'(a_count),    32'd2);
    checkOutput("bp a_head",   32'(bus.a_data), 32'd10);
    step();
    checkOutput("bp a_second", 32'(bus.a_data), 32'd11);
    step();
    checkOutput("bp a_empty",  32'(a_count),    32'd0);
    checkOutput("bp a_hold",   32'(bus.a_data), 32'd11);
    applyStimulus(0, 0, '0, 0, 1);
    step();

    // Simultaneous push/pop with pointer wrap
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, WIDTH'(i), 1, 0);
      step();
      checkOutput("wrap a_data",  32'(bus.a_data), 32'(i));
      checkOutput("wrap a_count", 32'(a_count),    32'd1);
    end
    applyStimulus(0, 0, '0, 1, 0);
    step();

    // Reset mid-operation
    applyStimulus(1, 0, 23'd100, 0, 0);
    step();
    applyStimulus(1, 0, 23'd101, 0, 0);
    step();
    applyStimulus(1, 1, 23'd200, 0, 0);
    step();
    applyStimulus(0, 0, '0, 0, 0);
    checkOutput("pre-reset a_count", 32'(a_count), 32'd2);
    checkOutput("pre-reset b_count", 32'(b_count), 32'd1);
    #3;
    rst_n = 1'b0;
    clearModel();
    #1;
    checkOutput("async a_valid", 32'(bus.a_valid), 32'd0);
    checkOutput("async b_valid", 32'(bus.b_valid), 32'd0);
    checkOutput("async a_data",  32'(bus.a_data),  32'd0);
    checkOutput("async b_data",  32'(bus.b_data),  32'd0);
    checkOutput("async a_count", 32'(a_count),     32'd0);
    checkOutput("async b_count", 32'(b_count),     32'd0);
    checkOutput("async in_ready", 32'(bus.in_ready), 32'd1);
    #2;
    rst_n = 1'b1;
    step();
    checkOutput("post-reset a_count", 32'(a_count),    32'd0);
    checkOutput("post-reset a_data",  32'(bus.a_data), 32'd0);
    checkOutput("post-reset b_valid", 32'(bus.b_valid), 32'd0);

    // Randomized traffic against the queue model
    for (int n = 0; n < 800; n++) begin
      applyStimulus(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
                    WIDTH'($urandom), bit'($urandom_range(0, 2) != 0),
                    bit'($urandom_range(0, 1)));
      step();
    end
    applyStimulus(0, 0, '0, 1, 1);
    repeat (4) step();

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
